// File: rtl/note_game_pkg.sv
// Shared types and defaults for the note game song scheduler.
package note_game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int DEF_FREQ_W   = 16;
    localparam int DEF_SONG_LEN = 32;
    localparam int END_MARKER   = 0;

endpackage

// File: rtl/song_rom.sv
// Synchronous single-port song ROM, 1-cycle read latency.
// The image is an elaboration-time parameter, so no load file is needed to simulate or synthesize it.
module song_rom #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter logic [DEPTH-1:0][WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        data_q <= INIT[addr];
    end

    assign data = data_q;

endmodule

// File: rtl/wall_note_scheduler.sv
// Round-robin song scheduler: fetches the next note from the song ROM and
// hands it to exactly one requesting wall per SERVE slot.
module wall_note_scheduler
    import note_game_pkg::*;
#(
    parameter int N_WALLS  = 3,
    parameter int SONG_LEN = DEF_SONG_LEN,
    parameter int FREQ_W   = DEF_FREQ_W,
    parameter int IDX_W    = $clog2(SONG_LEN),
    parameter logic [SONG_LEN-1:0][FREQ_W-1:0] SONG_INIT = '0
) (
    input  logic               pixel_clk_in,
    input  logic               rst_n_in,
    input  logic               start_in,
    input  logic               abort_in,
    input  logic [N_WALLS-1:0] req_in,
    output logic [N_WALLS-1:0] grant_out,
    output logic [FREQ_W-1:0]  freq_out,
    output logic [IDX_W-1:0]   note_idx_out,
    output logic               busy_out,
    output logic               final_note_out,
    output logic               done_out
);

    localparam int PTR_W = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [FREQ_W-1:0]  note_q, note_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [IDX_W-1:0]   nidx_q, nidx_d;
    logic [N_WALLS-1:0] grant;
    logic               final_note;
    logic [PTR_W-1:0]   win;
    logic [FREQ_W-1:0]  rom_data;

    // First requester at or after ptr, scanning upward modulo N_WALLS.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_WALLS-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               k;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_WALLS; i++) begin
            k = int'(ptr) + i;
            if (k >= N_WALLS) k = k - N_WALLS;
            if (!found && req[k]) begin
                pick  = PTR_W'(k);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // The address follows idx_d so the read issued with a transition lands in LOAD.
    song_rom #(
        .DEPTH(SONG_LEN),
        .WIDTH(FREQ_W),
        .AW   (IDX_W),
        .INIT (SONG_INIT)
    ) u_rom (
        .clk (pixel_clk_in),
        .addr(idx_d),
        .data(rom_data)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        note_d     = note_q;
        freq_d     = freq_q;
        nidx_d     = nidx_q;
        grant      = '0;
        final_note = 1'b0;
        win        = rr_pick(req_in, ptr_q);

        if (abort_in) begin
            state_d = IDLE;
            idx_d   = '0;
            ptr_d   = '0;
            note_d  = '0;
            freq_d  = '0;
            nidx_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_in) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end
                end
                LOAD: begin
                    note_d  = rom_data;
                    state_d = (rom_data == FREQ_W'(END_MARKER)) ? DONE : SERVE;
                end
                SERVE: begin
                    if (|req_in) begin
                        grant[win] = 1'b1;
                        freq_d     = note_q;
                        nidx_d     = idx_q;
                        ptr_d      = (win == PTR_W'(N_WALLS - 1)) ? '0 : PTR_W'(win + 1'b1);
                        if (idx_q == IDX_W'(SONG_LEN - 1)) begin
                            final_note = 1'b1;
                            state_d    = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = LOAD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            note_q  <= '0;
            freq_q  <= '0;
            nidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            note_q  <= note_d;
            freq_q  <= freq_d;
            nidx_q  <= nidx_d;
        end
    end

    // Grant and its payload are visible in the grant cycle, then held.
    assign grant_out      = grant;
    assign freq_out       = (|grant) ? note_q : freq_q;
    assign note_idx_out   = (|grant) ? idx_q : nidx_q;
    assign busy_out       = (state_q == LOAD) || (state_q == SERVE);
    assign final_note_out = final_note;
    assign done_out       = (state_q == DONE);

endmodule

// File: tb/tb_wall_note_scheduler.sv
// Directed bench: song with end marker on one instance, 4-note song without marker on another.
module tb_wall_note_scheduler;

    localparam logic [31:0][15:0] SONG_A = {{27{16'd0}}, 16'd0, 16'd349, 16'd622, 16'd440, 16'd262};
    localparam logic [3:0][15:0]  SONG_B = {16'd400, 16'd300, 16'd200, 16'd100};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic [2:0]  req_a, req_b, gnt_a, gnt_b;
    logic [15:0] freq_a, freq_b;
    logic [4:0]  nidx_a;
    logic [1:0]  nidx_b;
    logic        busy_a, fin_a, done_a, busy_b, fin_b, done_b;

    int nvec = 0;
    int nerr = 0;

    wall_note_scheduler #(.N_WALLS(3), .SONG_LEN(32), .FREQ_W(16), .SONG_INIT(SONG_A)) dut_a (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .abort_in(abort_a),
        .req_in(req_a), .grant_out(gnt_a), .freq_out(freq_a), .note_idx_out(nidx_a),
        .busy_out(busy_a), .final_note_out(fin_a), .done_out(done_a));

    wall_note_scheduler #(.N_WALLS(3), .SONG_LEN(4), .FREQ_W(16), .SONG_INIT(SONG_B)) dut_b (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .abort_in(abort_b),
        .req_in(req_b), .grant_out(gnt_b), .freq_out(freq_b), .note_idx_out(nidx_b),
        .busy_out(busy_b), .final_note_out(fin_b), .done_out(done_b));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  eg [4];
        logic [15:0] ef [4];
        logic [15:0] eb [4];
        eg = '{3'b001, 3'b010, 3'b100, 3'b001};
        ef = '{16'd262, 16'd440, 16'd622, 16'd349};
        eb = '{16'd100, 16'd200, 16'd300, 16'd400};

        rst_n = 1'b1;
        start_a = 0; abort_a = 0; req_a = '0;
        start_b = 0; abort_b = 0; req_b = '0;

        // async reset asserted mid-cycle
        #12 rst_n = 1'b0;
        #1;
        chk("rst_grant", gnt_a, 0);
        chk("rst_freq", freq_a, 0);
        chk("rst_idx", nidx_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_final", fin_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_b_done", done_b, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single requests
        start_a = 1; #2;
        chk("idle_busy", busy_a, 0);
        tick(); start_a = 0; req_a = 3'b001; #2;
        chk("load_busy", busy_a, 1);
        chk("load_nogrant", gnt_a, 0);
        tick(); #2;
        chk("g0_grant", gnt_a, 3'b001);
        chk("g0_freq", freq_a, 262);
        chk("g0_idx", nidx_a, 0);
        tick(); req_a = 3'b000; #2;
        chk("g0_hold_grant", gnt_a, 0);
        chk("g0_hold_freq", freq_a, 262);
        tick(); req_a = 3'b010; #2;
        chk("g1_grant", gnt_a, 3'b010);
        chk("g1_freq", freq_a, 440);
        chk("g1_idx", nidx_a, 1);

        // abort during LOAD with all requests up
        tick(); req_a = 3'b111; abort_a = 1; #2;
        chk("abort_nogrant", gnt_a, 0);
        tick(); abort_a = 0; req_a = 3'b000; #2;
        chk("abort_busy", busy_a, 0);
        chk("abort_freq", freq_a, 0);
        chk("abort_idx", nidx_a, 0);

        // restart, all walls requesting continuously
        start_a = 1;
        tick(); start_a = 0; req_a = 3'b111; #2;
        chk("rr_load_nogrant", gnt_a, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("rr%0d_grant", i), gnt_a, eg[i]);
            chk($sformatf("rr%0d_freq", i), freq_a, ef[i]);
            chk($sformatf("rr%0d_idx", i), nidx_a, i);
            chk($sformatf("rr%0d_final", i), fin_a, 0);
            tick(); #2;
            chk($sformatf("rr%0d_gap", i), gnt_a, 0);
            chk($sformatf("rr%0d_done_lo", i), done_a, 0);
            tick();
        end

        // end marker reached
        #2;
        chk("end_done", done_a, 1);
        chk("end_busy", busy_a, 0);
        chk("end_grant", gnt_a, 0);
        chk("end_final", fin_a, 0);
        chk("end_freq", freq_a, 349);
        chk("end_idx", nidx_a, 3);
        tick(); #2;
        chk("done_req_grant", gnt_a, 0);
        abort_a = 1;
        tick(); abort_a = 0; req_a = 3'b000; #2;
        chk("done_abort_done", done_a, 0);
        start_a = 1; abort_a = 1;
        tick(); start_a = 0; abort_a = 0; #2;
        chk("start_abort_busy", busy_a, 0);

        // 4-note song without end marker
        start_b = 1;
        tick(); start_b = 0; req_b = 3'b111;
        tick();
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("b%0d_grant", i), gnt_b, eg[i]);
            chk($sformatf("b%0d_freq", i), freq_b, eb[i]);
            chk($sformatf("b%0d_idx", i), nidx_b, i);
            chk($sformatf("b%0d_final", i), fin_b, (i == 3) ? 1 : 0);
            chk($sformatf("b%0d_done_lo", i), done_b, 0);
            tick(); #2;
            chk($sformatf("b%0d_next_grant", i), gnt_b, 0);
            chk($sformatf("b%0d_next_done", i), done_b, (i == 3) ? 1 : 0);
            chk($sformatf("b%0d_next_final", i), fin_b, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
